// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Integer register file for the pipelined core with write-back source
//   selection, same-cycle write-to-read bypass and a per-register busy
//   scoreboard that stalls decode on RAW/WAW hazards.
//
// Ports
//   CLK, Reset             clock; synchronous active-high reset
//   Rs1, Rs2               combinational read addresses
//   IssueValid/IssueWr/IssueRd
//                          decode-side issue request
//   WbValid/WbRd/WbSel     write-back request and source select
//   AluOutput, Datain, Extend, PC, Cmp
//                          write-back data sources
//   ReadData1, ReadData2   combinational read data (with bypass)
//   Stall                  combinational: decode must hold this cycle
//   DB                     registered copy of the last accepted write data
//   BusyMask               registered scoreboard bits
//   WbErr                  registered one-cycle write-back error pulse
//
// Handshake: an issue is accepted on a rising edge when IssueValid=1 and
// Stall=0 in that cycle (Stall acts as an inverted ready). The write-back
// side has no back-pressure: WbValid=1 is always consumed in its cycle.
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [AW-1:0]   Rs1,
  input  logic [AW-1:0]   Rs2,
  input  logic            IssueValid,
  input  logic            IssueWr,
  input  logic [AW-1:0]   IssueRd,
  input  logic            WbValid,
  input  logic [AW-1:0]   WbRd,
  input  logic [2:0]      WbSel,
  input  logic [XLEN-1:0] AluOutput,
  input  logic [XLEN-1:0] Datain,
  input  logic [XLEN-1:0] Extend,
  input  logic [XLEN-1:0] PC,
  input  logic            Cmp,
  output logic [XLEN-1:0] ReadData1,
  output logic [XLEN-1:0] ReadData2,
  output logic            Stall,
  output logic [XLEN-1:0] DB,
  output logic [NREG-1:0] BusyMask,
  output logic            WbErr
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] pc_plus4;
  logic            wb_legal;
  logic            wr_zero;
  logic            wr_acc;
  logic            wb_err_next;
  logic            haz_rs1;
  logic            haz_rs2;
  logic            haz_rd;
  logic            issue_set;

  // PC+4 deliberately wraps at 2^XLEN.
  assign pc_plus4 = PC + XLEN'(4);

  always_comb begin
    wb_data  = '0;
    wb_legal = 1'b1;
    case (WbSel)
      3'b000:  wb_data = AluOutput;
      3'b001:  wb_data = Datain;
      3'b010:  wb_data = pc_plus4;
      3'b011:  wb_data = {{(XLEN-1){1'b0}}, Cmp};
      3'b100:  wb_data = Extend;
      default: wb_legal = 1'b0;
    endcase
  end

  assign wr_zero = (ZERO_REG != 0) && (WbRd == '0);
  assign wr_acc  = WbValid && wb_legal && !wr_zero;

  // Later assignments take priority: zero register beats bypass beats array.
  always_comb begin
    ReadData1 = regs[Rs1];
    if ((BYPASS != 0) && wr_acc && (WbRd == Rs1)) ReadData1 = wb_data;
    if ((ZERO_REG != 0) && (Rs1 == '0)) ReadData1 = '0;
  end

  always_comb begin
    ReadData2 = regs[Rs2];
    if ((BYPASS != 0) && wr_acc && (WbRd == Rs2)) ReadData2 = wb_data;
    if ((ZERO_REG != 0) && (Rs2 == '0)) ReadData2 = '0;
  end

  // A busy register stops being a hazard when its result is forwarded now.
  assign haz_rs1 = busy[Rs1] && !((BYPASS != 0) && wr_acc && (WbRd == Rs1));
  assign haz_rs2 = busy[Rs2] && !((BYPASS != 0) && wr_acc && (WbRd == Rs2));
  assign haz_rd  = busy[IssueRd] && !((BYPASS != 0) && wr_acc && (WbRd == IssueRd));

  assign Stall = IssueValid && (haz_rs1 || haz_rs2 || (IssueWr && haz_rd));

  assign issue_set = IssueValid && !Stall && IssueWr &&
                     !((ZERO_REG != 0) && (IssueRd == '0));

  // Set is applied after clear so a same-index set wins.
  always_comb begin
    busy_next = busy;
    if (wr_acc)    busy_next[WbRd]    = 1'b0;
    if (issue_set) busy_next[IssueRd] = 1'b1;
  end

  // Illegal selects always flag; non-busy targets flag unless the target is
  // the hard-wired zero register.
  assign wb_err_next = WbValid && (!wb_legal || (!wr_zero && !busy[WbRd]));

  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy  <= '0;
      DB    <= '0;
      WbErr <= 1'b0;
    end else begin
      if (wr_acc) begin
        regs[WbRd] <= wb_data;
        DB         <= wb_data;
      end
      busy  <= busy_next;
      WbErr <= wb_err_next;
    end
  end

  assign BusyMask = busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1, rs2, issue_rd, wb_rd;
  logic        issue_valid, issue_wr, wb_valid, cmp;
  logic [2:0]  wb_sel;
  logic [31:0] alu_output, datain, extend, pc;

  logic [31:0] read_data1, read_data2, db, busy_mask;
  logic        stall, wb_err;
  logic [31:0] nb_read_data1, nb_read_data2, nb_db, nb_busy_mask;
  logic        nb_stall, nb_wb_err;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .CLK(clk), .Reset(reset), .Rs1(rs1), .Rs2(rs2),
    .IssueValid(issue_valid), .IssueWr(issue_wr), .IssueRd(issue_rd),
    .WbValid(wb_valid), .WbRd(wb_rd), .WbSel(wb_sel),
    .AluOutput(alu_output), .Datain(datain), .Extend(extend), .PC(pc), .Cmp(cmp),
    .ReadData1(read_data1), .ReadData2(read_data2), .Stall(stall),
    .DB(db), .BusyMask(busy_mask), .WbErr(wb_err)
  );

  regfile_scoreboard #(.BYPASS(0)) dut_nb (
    .CLK(clk), .Reset(reset), .Rs1(rs1), .Rs2(rs2),
    .IssueValid(issue_valid), .IssueWr(issue_wr), .IssueRd(issue_rd),
    .WbValid(wb_valid), .WbRd(wb_rd), .WbSel(wb_sel),
    .AluOutput(alu_output), .Datain(datain), .Extend(extend), .PC(pc), .Cmp(cmp),
    .ReadData1(nb_read_data1), .ReadData2(nb_read_data2), .Stall(nb_stall),
    .DB(nb_db), .BusyMask(nb_busy_mask), .WbErr(nb_wb_err)
  );

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        iv, iwr;
    logic [4:0]  ird, rs1, rs2;
    logic        wv;
    logic [4:0]  wrd;
    logic [2:0]  sel;
    logic [31:0] alu, din, ext, pc;
    logic        cmp;
    logic        e_stall;
    logic [31:0] e_rd1, e_rd2, e_db, e_busy;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic iv, logic iwr, logic [4:0] ird,
                              logic [4:0] r1, logic [4:0] r2, logic wv, logic [4:0] wrd,
                              logic [2:0] sel, logic [31:0] alu, logic [31:0] din,
                              logic [31:0] ext, logic [31:0] p, logic c, logic e_stall,
                              logic [31:0] e_rd1, logic [31:0] e_rd2, logic [31:0] e_db,
                              logic [31:0] e_busy, logic e_err);
    vec_t v;
    v.name = nm; v.iv = iv; v.iwr = iwr; v.ird = ird; v.rs1 = r1; v.rs2 = r2;
    v.wv = wv; v.wrd = wrd; v.sel = sel; v.alu = alu; v.din = din; v.ext = ext;
    v.pc = p; v.cmp = c; v.e_stall = e_stall; v.e_rd1 = e_rd1; v.e_rd2 = e_rd2;
    v.e_db = e_db; v.e_busy = e_busy; v.e_err = e_err;
    return v;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic drive_idle();
    issue_valid = 0; issue_wr = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    wb_valid = 0; wb_rd = 0; wb_sel = 0; alu_output = 0; datain = 0;
    extend = 0; pc = 0; cmp = 0;
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic apply(vec_t v);
    @(negedge clk);
    issue_valid = v.iv; issue_wr = v.iwr; issue_rd = v.ird; rs1 = v.rs1; rs2 = v.rs2;
    wb_valid = v.wv; wb_rd = v.wrd; wb_sel = v.sel; alu_output = v.alu;
    datain = v.din; extend = v.ext; pc = v.pc; cmp = v.cmp;
    #2;
    check({v.name, ".stall"}, {31'b0, stall}, {31'b0, v.e_stall});
    check({v.name, ".rd1"}, read_data1, v.e_rd1);
    check({v.name, ".rd2"}, read_data2, v.e_rd2);
    @(posedge clk);
    #1;
    check({v.name, ".db"}, db, v.e_db);
    check({v.name, ".busy"}, busy_mask, v.e_busy);
    check({v.name, ".wberr"}, {31'b0, wb_err}, {31'b0, v.e_err});
  endtask

  // ---------------- test ----------------
  initial begin
    //               name           iv iwr ird rs1 rs2 wv wrd sel  alu            din            ext            pc             cmp  stall rd1            rd2            db             busy           err
    vecs.push_back(mk("issue_rd5",   1, 1,  5,  0,  0, 0, 0, 3'd0, 32'h0,         32'h0,         32'h0,         32'h0,         0,   0,    32'h0,         32'h0,         32'h1234,      32'h20,        0));
    vecs.push_back(mk("raw_stall5",  1, 0,  0,  5,  0, 0, 0, 3'd0, 32'h0,         32'h0,         32'h0,         32'h0,         0,   1,    32'h0,         32'h0,         32'h1234,      32'h20,        0));
    vecs.push_back(mk("bypass5",     1, 0,  0,  5,  0, 1, 5, 3'd0, 32'h1234,      32'h0,         32'h0,         32'h0,         0,   0,    32'h1234,      32'h0,         32'h1234,      32'h0,         0));
    vecs.push_back(mk("read5",       0, 0,  0,  5,  5, 0, 0, 3'd0, 32'h0,         32'h0,         32'h0,         32'h0,         0,   0,    32'h1234,      32'h1234,      32'h1234,      32'h0,         0));
    vecs.push_back(mk("issue_rd3",   1, 1,  3,  0,  0, 0, 0, 3'd0, 32'h0,         32'h0,         32'h0,         32'h0,         0,   0,    32'h0,         32'h0,         32'h1234,      32'h8,         0));
    vecs.push_back(mk("pc4_wrap",    0, 0,  0,  3,  0, 1, 3, 3'd2, 32'h0,         32'h0,         32'h0,         32'hFFFFFFFC,  0,   0,    32'h0,         32'h0,         32'h0,         32'h0,         0));
    vecs.push_back(mk("issue_rd4",   1, 1,  4,  3,  0, 0, 0, 3'd0, 32'h0,         32'h0,         32'h0,         32'h0,         0,   0,    32'h0,         32'h0,         32'h0,         32'h10,        0));
    vecs.push_back(mk("wb_cmp",      0, 0,  0,  0,  4, 1, 4, 3'd3, 32'hFFFF,      32'h0,         32'h0,         32'h0,         1,   0,    32'h0,         32'h1,         32'h1,         32'h0,         0));
    vecs.push_back(mk("wb_x0",       0, 0,  0,  0,  0, 1, 0, 3'd0, 32'hDEADBEEF,  32'h0,         32'h0,         32'h0,         0,   0,    32'h0,         32'h0,         32'h1,         32'h0,         0));
    vecs.push_back(mk("issue_rd0",   1, 1,  0,  0,  0, 0, 0, 3'd0, 32'h0,         32'h0,         32'h0,         32'h0,         0,   0,    32'h0,         32'h0,         32'h1,         32'h0,         0));
    vecs.push_back(mk("issue_rd7",   1, 1,  7,  0,  0, 0, 0, 3'd0, 32'h0,         32'h0,         32'h0,         32'h0,         0,   0,    32'h0,         32'h0,         32'h1,         32'h80,        0));
    vecs.push_back(mk("wb7_iss7",    1, 1,  7,  7,  0, 1, 7, 3'd4, 32'h0,         32'h0,         32'hCAFE0000,  32'h0,         0,   0,    32'hCAFE0000,  32'h0,         32'hCAFE0000,  32'h80,        0));
    vecs.push_back(mk("waw_stall",   1, 1,  7,  0,  0, 0, 0, 3'd0, 32'h0,         32'h0,         32'h0,         32'h0,         0,   1,    32'h0,         32'h0,         32'hCAFE0000,  32'h80,        0));
    vecs.push_back(mk("illegal110",  0, 0,  0,  7,  0, 1, 7, 3'd6, 32'h55,        32'h0,         32'h0,         32'h0,         0,   0,    32'hCAFE0000,  32'h0,         32'hCAFE0000,  32'h80,        1));
    vecs.push_back(mk("err_drop",    0, 0,  0,  7,  0, 0, 0, 3'd0, 32'h0,         32'h0,         32'h0,         32'h0,         0,   0,    32'hCAFE0000,  32'h0,         32'hCAFE0000,  32'h80,        0));
    vecs.push_back(mk("wb7_load",    0, 0,  0,  0,  7, 1, 7, 3'd1, 32'h0,         32'h0BADF00D,  32'h0,         32'h0,         0,   0,    32'h0,         32'h0BADF00D,  32'h0BADF00D,  32'h0,         0));
    vecs.push_back(mk("wb_nonbusy",  0, 0,  0,  6,  0, 1, 6, 3'd0, 32'h66,        32'h0,         32'h0,         32'h0,         0,   0,    32'h66,        32'h0,         32'h66,        32'h0,         1));
    vecs.push_back(mk("read6_7",     0, 0,  0,  6,  7, 0, 0, 3'd0, 32'h0,         32'h0,         32'h0,         32'h0,         0,   0,    32'h66,        32'h0BADF00D,  32'h66,        32'h0,         0));

    drive_idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Reset state: every register reads 0, no busy bits, no stall.
    @(negedge clk);
    for (int i = 1; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(32 - i);
      #1;
      check($sformatf("reset_rd1_x%0d", i), read_data1, 32'h0);
      check($sformatf("reset_rd2_x%0d", 32 - i), read_data2, 32'h0);
    end
    check("reset_busy", busy_mask, 32'h0);
    check("reset_db", db, 32'h0);
    check("reset_wberr", {31'b0, wb_err}, 32'h0);
    issue_valid = 1; rs1 = 5'd9;
    #1 check("reset_stall", {31'b0, stall}, 32'h0);

    // BYPASS=0 versus BYPASS=1 on a RAW hazard resolved by same-cycle write-back.
    @(negedge clk);
    drive_idle();
    issue_valid = 1; issue_wr = 1; issue_rd = 10;
    @(posedge clk); #1;
    check("nb_issue_busy", busy_mask, 32'h400);
    check("nb_issue_busy_nb", nb_busy_mask, 32'h400);
    @(negedge clk);
    drive_idle();
    issue_valid = 1; rs1 = 10; wb_valid = 1; wb_rd = 10; wb_sel = 3'd0; alu_output = 32'h1234;
    #2;
    check("byp_stall", {31'b0, stall}, 32'h0);
    check("byp_rd1", read_data1, 32'h1234);
    check("nb_stall_wbcycle", {31'b0, nb_stall}, 32'h1);
    check("nb_rd1_wbcycle", nb_read_data1, 32'h0);
    @(posedge clk); #1;
    check("byp_busy_clear", busy_mask, 32'h0);
    check("nb_busy_clear", nb_busy_mask, 32'h0);
    check("nb_db", nb_db, 32'h1234);
    @(negedge clk);
    drive_idle();
    issue_valid = 1; rs1 = 10;
    #2;
    check("nb_stall_next", {31'b0, nb_stall}, 32'h0);
    check("nb_rd1_next", nb_read_data1, 32'h1234);
    check("byp_rd1_next", read_data1, 32'h1234);
    @(posedge clk); #1;

    // Table-driven main sequence.
    foreach (vecs[i]) apply(vecs[i]);

    // Reset while an issue is pending discards the busy bit.
    @(negedge clk);
    drive_idle();
    issue_valid = 1; issue_wr = 1; issue_rd = 9;
    @(posedge clk); #1;
    check("pend_busy9", busy_mask, 32'h200);
    @(negedge clk);
    reset = 1;
    issue_valid = 1; issue_wr = 1; issue_rd = 11;
    wb_valid = 1; wb_rd = 9; wb_sel = 3'd0; alu_output = 32'h77;
    @(posedge clk); #1;
    reset = 0;
    check("rst_busy", busy_mask, 32'h0);
    check("rst_db", db, 32'h0);
    check("rst_wberr", {31'b0, wb_err}, 32'h0);
    @(negedge clk);
    drive_idle();
    rs1 = 9; rs2 = 5;
    #2;
    check("rst_x9", read_data1, 32'h0);
    check("rst_x5", read_data2, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    drive_idle();
    rs1 = 9; wb_valid = 1; wb_rd = 9; wb_sel = 3'd0; alu_output = 32'h99;
    #2;
    check("late_wb9_byp", read_data1, 32'h99);
    @(posedge clk); #1;
    check("late_wb9_err", {31'b0, wb_err}, 32'h1);
    check("late_wb9_db", db, 32'h99);
    @(negedge clk);
    drive_idle();
    rs1 = 9;
    #2;
    check("late_x9", read_data1, 32'h99);
    @(posedge clk); #1;
    check("late_err_drop", {31'b0, wb_err}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor of the single-cycle CPU register file, built for the pipelined core.
- Holds the integer register array and selects write-back data from ALU, memory, PC+4, compare or immediate.
- Adds same-cycle write-to-read bypass and a per-register busy scoreboard that stalls decode on RAW/WAW hazards.
- Sits between the decode stage (read and issue side) and the write-back stage.

Parameters:
XLEN, 32, data width in bits.
NREG, 32, number of architectural registers; must be a power of 2.
AW, $clog2(NREG), register address width.
ZERO_REG, 1, if 1, register 0 reads as 0, is never written and is never busy.
BYPASS, 1, if 1, same-cycle write-back data is forwarded to the read ports and clears hazards.

Ports:
CLK  in  1  clock; all state changes on rising edge.
Reset  in  1  synchronous, active-high reset.
Rs1  in  AW  read address, port 1.
Rs2  in  AW  read address, port 2.
IssueValid  in  1  decode stage presents an instruction this cycle.
IssueWr  in  1  issuing instruction will write IssueRd.
IssueRd  in  AW  destination register of the issuing instruction.
WbValid  in  1  write-back stage presents a result this cycle.
WbRd  in  AW  write-back destination register.
WbSel  in  3  write-back source select.
AluOutput  in  XLEN  ALU result.
Datain  in  XLEN  load data.
Extend  in  XLEN  immediate (lui-style) value.
PC  in  XLEN  PC of the write-back instruction.
Cmp  in  1  compare result (slt-style).
ReadData1  out  XLEN  port 1 read data.
ReadData2  out  XLEN  port 2 read data.
Stall  out  1  decode must hold the instruction this cycle.
DB  out  XLEN  registered copy of the last accepted write data.
BusyMask  out  NREG  registered scoreboard bits.
WbErr  out  1  registered pulse flagging a write-back to a non-busy register.

Behaviour:
- Reset: synchronous and active-high, sampled on the CLK rising edge.
  - Clears every register, BusyMask, DB and WbErr to 0.
  - Discards all pending issues; writes and issues presented in a reset cycle are ignored.
- WbData selection by WbSel:
  - 000 AluOutput; 001 Datain; 010 PC+4, truncated to XLEN (wraps at 2^XLEN); 011 {XLEN-1 zeros, Cmp}; 100 Extend.
  - 101, 110 and 111 are illegal: no write, no busy clear, WbErr=1 on the next cycle.
- Write accepted when WbValid, WbSel is legal, and not (ZERO_REG and WbRd==0).
  - On acceptance, at the edge: reg[WbRd]<=WbData and DB<=WbData. Otherwise DB holds its value.
- Reads are combinational, evaluated in the order below:
  - ZERO_REG and address 0 -> 0.
  - BYPASS, accepted write and WbRd==address -> WbData.
  - Otherwise reg[address].
- A hazard exists on address A when busy[A] is set and not (BYPASS and an accepted write with WbRd==A).
- Stall = IssueValid and (hazard(Rs1) or hazard(Rs2) or (IssueWr and hazard(IssueRd))).
  - Stall is combinational, with zero-cycle latency.
  - Rs1 and Rs2 are always treated as used; decode drives 0 for unused operands.
- Scoreboard update at the edge:
  - An accepted write clears busy[WbRd].
  - IssueValid, !Stall, IssueWr, and not (ZERO_REG and IssueRd==0) sets busy[IssueRd].
  - If a set and a clear hit the same index in the same cycle, the set wins.
- WbErr <= 1 for one cycle after a write that is illegal or targets a non-busy register (ZERO_REG target excluded). A write to a non-busy register is still performed.
- With BYPASS=0, a same-cycle write-back does not clear a hazard; the stall persists one more cycle, then the register-file read returns the new value.

Test Plan:
- Reset, then read x1..x31 -> all 0; BusyMask=0; Stall=0; DB=0.
- Issue rd=5 (IssueWr=1); next cycle issue with Rs1=5 -> Stall=1. Write-back x5 with WbSel=000, AluOutput=0x1234 in the same cycle -> BYPASS=1: Stall=0, ReadData1=0x1234, busy[5] clears. BYPASS=0: Stall=1 that cycle, Stall=0 the next.
- Write-back x3 with WbSel=010, PC=0xFFFFFFFC -> x3=0x00000000 (wrap), DB=0. Write-back with WbSel=011, Cmp=1 -> value 0x00000001.
- Write-back to x0 with AluOutput=0xDEADBEEF -> x0 still reads 0, DB unchanged. Issue rd=0 -> BusyMask unchanged.
- In one cycle, write-back x7 (busy) and issue rd=7 -> busy[7] remains 1. WbSel=110 -> no write, WbErr pulses once.
- Issue rd=9, then assert Reset before write-back -> busy[9]=0. A later write-back of x9 writes the value and WbErr=1.
